// File: rtl/gcn_fetch_unit.sv
// GCN operand fetch: loads weight columns and COO edges, then streams
// feature rows to the compute datapath under a valid/ready handshake.
module gcn_fetch_unit #(
  parameter int FEATURE_ROWS    = 6,
  parameter int FEATURE_COLS    = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_WIDTH   = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  input  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] data_in,
  output logic [COO_BW-1:0]        coo_address,
  input  logic [2*COO_BW-1:0]      coo_in,
  output logic [WEIGHT_COLS-1:0][FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]
                                   weight_buf,
  output logic [COO_NUM_OF_COLS-1:0][COO_BW-1:0] coo_src,
  output logic [COO_NUM_OF_COLS-1:0][COO_BW-1:0] coo_dst,
  output logic                     weights_loaded,
  output logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] feature_row,
  output logic [$clog2(FEATURE_ROWS)-1:0] feature_row_idx,
  output logic                     feature_valid,
  input  logic                     feature_ready,
  output logic                     done
);

  localparam int WB = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int RB = $clog2(FEATURE_ROWS);
  localparam logic [WB-1:0] W_LAST = WB'(WEIGHT_COLS - 1);
  localparam logic [COO_BW-1:0] E_LAST = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [RB-1:0] R_LAST = RB'(FEATURE_ROWS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FB = ADDRESS_WIDTH'(FEATURE_BASE);

  typedef enum logic [2:0] {
    IDLE, W_REQ, C_REQ, F_REQ, F_HOLD, DONE
  } state_t;

  state_t            state_q;
  logic [WB-1:0]     c_q;
  logic [RB-1:0]     r_q;
  logic [WB-1:0]     c_d;
  logic [RB-1:0]     r_d;
  logic [COO_BW-1:0] e_d;

  assign c_d = c_q + 1'b1;
  assign r_d = r_q + 1'b1;
  assign e_d = coo_address + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      c_q             <= '0;
      r_q             <= '0;
      read_address    <= '0;
      enable_read     <= 1'b0;
      coo_address     <= '0;
      weight_buf      <= '0;
      coo_src         <= '0;
      coo_dst         <= '0;
      weights_loaded  <= 1'b0;
      feature_row     <= '0;
      feature_row_idx <= '0;
      feature_valid   <= 1'b0;
      done            <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q        <= W_REQ;
            c_q            <= '0;
            read_address   <= '0;
            enable_read    <= 1'b1;
            weights_loaded <= 1'b0;
          end
        end
        W_REQ: begin
          weight_buf[c_q] <= data_in;
          if (c_q == W_LAST) begin
            state_q     <= C_REQ;
            enable_read <= 1'b0;
            coo_address <= '0;
          end else begin
            c_q          <= c_d;
            read_address <= ADDRESS_WIDTH'(c_d);
          end
        end
        C_REQ: begin
          coo_src[coo_address] <= coo_in[2*COO_BW-1:COO_BW];
          coo_dst[coo_address] <= coo_in[COO_BW-1:0];
          if (coo_address == E_LAST) begin
            state_q        <= F_REQ;
            r_q            <= '0;
            read_address   <= FB;
            enable_read    <= 1'b1;
            weights_loaded <= 1'b1;
          end else begin
            coo_address <= e_d;
          end
        end
        F_REQ: begin
          feature_row     <= data_in;
          feature_row_idx <= r_q;
          enable_read     <= 1'b0;
          feature_valid   <= 1'b1;
          state_q         <= F_HOLD;
        end
        F_HOLD: begin
          if (feature_ready) begin
            feature_valid <= 1'b0;
            if (r_q == R_LAST) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              // next row address is issued together with the accept
              r_q          <= r_d;
              read_address <= FB + ADDRESS_WIDTH'(r_d);
              enable_read  <= 1'b1;
              state_q      <= F_REQ;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_fetch_unit.sv
// Directed self-checking bench for gcn_fetch_unit: reset, nominal run,
// backpressure, start protocol, ignored start and mid-run reset.
module tb_gcn_fetch_unit;
  localparam int FR = 6;
  localparam int FC = 96;
  localparam int WC = 3;
  localparam int FW = 5;
  localparam int AW = 13;
  localparam int FB = 512;
  localparam int NE = 6;
  localparam int CB = 3;

  typedef logic [FC-1:0][FW-1:0] row_t;

  localparam int SRC [NE] = '{1, 0, 3, 5, 2, 4};
  localparam int DST [NE] = '{2, 4, 0, 1, 5, 3};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] read_address;
  logic enable_read;
  row_t data_in;
  logic [CB-1:0] coo_address;
  logic [2*CB-1:0] coo_in;
  logic [WC-1:0][FC-1:0][FW-1:0] weight_buf;
  logic [NE-1:0][CB-1:0] coo_src;
  logic [NE-1:0][CB-1:0] coo_dst;
  logic weights_loaded;
  row_t feature_row;
  logic [2:0] feature_row_idx;
  logic feature_valid;
  logic feature_ready = 1'b1;
  logic done;

  gcn_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .read_address(read_address), .enable_read(enable_read),
    .data_in(data_in), .coo_address(coo_address), .coo_in(coo_in),
    .weight_buf(weight_buf), .coo_src(coo_src), .coo_dst(coo_dst),
    .weights_loaded(weights_loaded), .feature_row(feature_row),
    .feature_row_idx(feature_row_idx), .feature_valid(feature_valid),
    .feature_ready(feature_ready), .done(done)
  );

  always #5 clk = ~clk;

  function automatic row_t row_vec(input int a);
    row_t v;
    int key;
    key = (a >= FB) ? (a - FB + 3) : a;
    for (int j = 0; j < FC; j++) v[j] = FW'((key * 7 + j * 3 + 1) % 32);
    return v;
  endfunction

  always_comb data_in = row_vec(int'(read_address));

  always_comb begin
    coo_in = '0;
    if (int'(coo_address) < NE)
      coo_in = {CB'(SRC[coo_address]), CB'(DST[coo_address])};
  end

  int pass_n = 0;
  int total_n = 0;
  int addr_log[$];
  int lat, rows_acc, rows_bad, hold_n, overlap;
  logic wl_start;

  function automatic bit addr_ok();
    if (addr_log.size() != WC + FR) return 1'b0;
    for (int i = 0; i < WC + FR; i++)
      if (addr_log[i] != ((i < WC) ? i : FB + i - WC)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int stall_row, input int stall_n, input bit tog);
    int stall_left;
    stall_left = stall_n;
    addr_log.delete();
    lat = -1; rows_acc = 0; rows_bad = 0; hold_n = 0; overlap = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 80 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) wl_start = weights_loaded;
      if (enable_read) addr_log.push_back(int'(read_address));
      if (enable_read && feature_valid) overlap++;
      if (tog && feature_valid) start = ~start;
      feature_ready = 1'b1;
      if (feature_valid && int'(feature_row_idx) == stall_row) begin
        hold_n++;
        if (feature_row !== row_vec(FB + stall_row)) rows_bad++;
        if (stall_left > 0) begin
          feature_ready = 1'b0;
          stall_left--;
        end
      end
      if (feature_valid && feature_ready) begin
        if (int'(feature_row_idx) != rows_acc ||
            feature_row !== row_vec(FB + rows_acc)) rows_bad++;
        rows_acc++;
      end
      if (done) lat = k;
    end
    feature_ready = 1'b1;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_n++;
    if (read_address !== '0 || enable_read !== 1'b0)
      $display("FAIL reset_read: addr=%0d en=%b want 0/0",
               read_address, enable_read);
    else pass_n++;
    total_n++;
    if (coo_address !== '0)
      $display("FAIL reset_coo_addr: got %0d want 0", coo_address);
    else pass_n++;
    total_n++;
    if (feature_valid !== 1'b0 || weights_loaded !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags: fv=%b wl=%b done=%b want 0",
               feature_valid, weights_loaded, done);
    else pass_n++;
    total_n++;
    if (weight_buf !== '0 || coo_src !== '0 || coo_dst !== '0)
      $display("FAIL reset_bufs: nonzero buffers, want 0");
    else pass_n++;
    total_n++;
    if (feature_row !== '0 || feature_row_idx !== '0)
      $display("FAIL reset_row: idx=%0d want 0", feature_row_idx);
    else pass_n++;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    begin
      int bad;
      bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (enable_read !== 1'b0 || feature_valid !== 1'b0 || done !== 1'b0)
          bad++;
      end
      total_n++;
      if (bad != 0) $display("FAIL idle_hold: %0d active cycles want 0", bad);
      else pass_n++;
    end
  endtask

  task automatic test_nominal();
    logic [WC-1:0][FC-1:0][FW-1:0] ew;
    logic [NE-1:0][CB-1:0] es, ed;
    run(-1, 0, 1'b0);
    total_n++;
    if (lat != 21) $display("FAIL nom_latency: got %0d want 21", lat);
    else pass_n++;
    total_n++;
    if (!addr_ok())
      $display("FAIL nom_addr_seq: %0d reads, seq wrong", addr_log.size());
    else pass_n++;
    for (int c = 0; c < WC; c++) ew[c] = row_vec(c);
    for (int e = 0; e < NE; e++) begin
      es[e] = CB'(SRC[e]);
      ed[e] = CB'(DST[e]);
    end
    total_n++;
    if (weight_buf !== ew) $display("FAIL nom_weights: got %h want %h",
                                    weight_buf, ew);
    else pass_n++;
    total_n++;
    if (coo_src !== es || coo_dst !== ed)
      $display("FAIL nom_coo: src=%h dst=%h want %h %h",
               coo_src, coo_dst, es, ed);
    else pass_n++;
    total_n++;
    if (rows_acc != FR || rows_bad != 0)
      $display("FAIL nom_rows: acc=%0d bad=%0d want 6/0", rows_acc, rows_bad);
    else pass_n++;
    total_n++;
    if (overlap != 0 || weights_loaded !== 1'b1)
      $display("FAIL nom_flags: overlap=%0d wl=%b want 0/1",
               overlap, weights_loaded);
    else pass_n++;
  endtask

  task automatic test_start_protocol();
    int bad;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b1 || enable_read !== 1'b0) bad++;
    end
    total_n++;
    if (bad != 0) $display("FAIL sp_no_rerun: %0d bad cycles want 0", bad);
    else pass_n++;
    drop_start();
    total_n++;
    if (done !== 1'b0 || weights_loaded !== 1'b1)
      $display("FAIL sp_idle: done=%b wl=%b want 0/1", done, weights_loaded);
    else pass_n++;
    run(-1, 0, 1'b0);
    total_n++;
    if (wl_start !== 1'b0)
      $display("FAIL sp_wl_clear: got %b want 0", wl_start);
    else pass_n++;
    total_n++;
    if (lat != 21 || !addr_ok() || rows_bad != 0)
      $display("FAIL sp_rerun: lat=%0d bad=%0d want 21/0", lat, rows_bad);
    else pass_n++;
  endtask

  task automatic test_backpressure();
    drop_start();
    run(2, 3, 1'b0);
    total_n++;
    if (lat != 24) $display("FAIL bp_latency: got %0d want 24", lat);
    else pass_n++;
    total_n++;
    if (hold_n != 4) $display("FAIL bp_hold: got %0d want 4", hold_n);
    else pass_n++;
    total_n++;
    if (!addr_ok() || overlap != 0)
      $display("FAIL bp_reads: %0d reads overlap=%0d want 9/0",
               addr_log.size(), overlap);
    else pass_n++;
    total_n++;
    if (rows_acc != FR || rows_bad != 0)
      $display("FAIL bp_rows: acc=%0d bad=%0d want 6/0", rows_acc, rows_bad);
    else pass_n++;
  endtask

  task automatic test_ignored_start();
    drop_start();
    run(-1, 0, 1'b1);
    total_n++;
    if (lat != 21) $display("FAIL ign_latency: got %0d want 21", lat);
    else pass_n++;
    total_n++;
    if (!addr_ok() || rows_bad != 0)
      $display("FAIL ign_addr_seq: %0d reads bad=%0d want 9/0",
               addr_log.size(), rows_bad);
    else pass_n++;
  endtask

  task automatic test_midrun_reset();
    drop_start();
    start = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    total_n++;
    if (coo_address !== 3'd3 || enable_read !== 1'b0)
      $display("FAIL mr_pos: coo=%0d en=%b want 3/0", coo_address, enable_read);
    else pass_n++;
    reset = 1'b0;
    #1;
    total_n++;
    if (coo_address !== '0 || read_address !== '0 || weight_buf !== '0 ||
        coo_src !== '0 || weights_loaded !== 1'b0 || done !== 1'b0)
      $display("FAIL mr_clear: coo=%0d addr=%0d wl=%b want all 0",
               coo_address, read_address, weights_loaded);
    else pass_n++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(-1, 0, 1'b0);
    total_n++;
    if (!addr_ok() || lat != 21)
      $display("FAIL mr_restart: first=%0d lat=%0d want 0/21",
               (addr_log.size() > 0) ? addr_log[0] : -1, lat);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_protocol();
    test_backpressure();
    test_ignored_start();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
